// File: rtl/cache_refill_ctrl.sv
// ============================================================================
//  Module      : cache_refill_ctrl
//  Description : Cache miss engine. Writes back a dirty victim block, then
//                fetches the missing block and streams it into the data array.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_refill_ctrl #(
    parameter int BLOCK_SIZE = 8
) (
    input  logic                       clock,
    input  logic                       rst,

    input  logic                       miss_req,
    input  logic [31:0]                miss_addr,
    input  logic                       victim_dirty,
    input  logic [31:0]                victim_addr,
    input  logic [32*BLOCK_SIZE-1:0]   victim_line,
    output logic                       busy,

    output logic                       fill_we,
    output logic [2:0]                 fill_idx,
    output logic [31:0]                fill_data,
    output logic                       fill_done,

    output logic                       dram_wr_req,
    output logic [31:0]                dram_wr_addr,
    output logic [31:0]                dram_wr_data,
    input  logic                       dram_wr_val,

    output logic                       dram_rd_req,
    output logic [31:0]                dram_rd_addr,
    input  logic [31:0]                dram_rd_data,
    input  logic                       dram_rd_val
);

    localparam logic [2:0]  c_LAST_IDX   = 3'(BLOCK_SIZE - 1);
    localparam logic [31:0] c_ALIGN_MASK = ~32'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       w_accept;
    logic                       w_rd_last;

    logic [31:0]                r_miss_base;
    logic [31:0]                r_victim_base;
    logic [32*BLOCK_SIZE-1:0]   r_victim_line;
    logic [2:0]                 r_wcnt;
    logic [2:0]                 r_rcnt;
    logic                       r_busy;
    logic                       r_rd_req;
    logic                       r_fill_we;
    logic [2:0]                 r_fill_idx;
    logic [31:0]                r_fill_data;
    logic                       r_fill_done;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rd_last    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (miss_req) begin
                    w_accept     = 1'b1;
                    w_next_state = victim_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                if (dram_wr_val && (r_wcnt == c_LAST_IDX)) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                if (dram_rd_val && (r_rcnt == c_LAST_IDX)) begin
                    w_rd_last    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_miss_base   <= '0;
            r_victim_base <= '0;
            r_victim_line <= '0;
            r_wcnt        <= '0;
            r_rcnt        <= '0;
            r_busy        <= 1'b0;
            r_rd_req      <= 1'b0;
            r_fill_we     <= 1'b0;
            r_fill_idx    <= '0;
            r_fill_data   <= '0;
            r_fill_done   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            // Busy stays up through the cycle that writes the final fill word.
            r_busy      <= (w_next_state != S_IDLE) || w_rd_last;
            r_rd_req    <= (w_next_state == S_FILL);
            r_fill_we   <= (r_state == S_FILL) && dram_rd_val;
            r_fill_done <= w_rd_last;

            if (w_accept) begin
                r_miss_base   <= miss_addr & c_ALIGN_MASK;
                r_victim_base <= victim_addr & c_ALIGN_MASK;
                r_victim_line <= victim_line;
                r_wcnt        <= '0;
                r_rcnt        <= '0;
            end

            // 3-bit counters wrap to zero on the eighth beat.
            if ((r_state == S_WB) && dram_wr_val) begin
                r_wcnt <= r_wcnt + 3'd1;
            end
            if ((r_state == S_FILL) && dram_rd_val) begin
                r_rcnt      <= r_rcnt + 3'd1;
                r_fill_idx  <= r_rcnt;
                r_fill_data <= dram_rd_data;
            end
        end
    end

    // Request drops in the same cycle as the last write beat so the DRAM
    // controller does not see it as a fresh request.
    assign dram_wr_req  = (r_state == S_WB) && !(dram_wr_val && (r_wcnt == c_LAST_IDX));
    assign dram_wr_data = r_victim_line[{r_wcnt, 5'd0} +: 32];
    assign dram_wr_addr = r_victim_base;
    assign dram_rd_req  = r_rd_req;
    assign dram_rd_addr = r_miss_base;
    assign busy         = r_busy;
    assign fill_we      = r_fill_we;
    assign fill_idx     = r_fill_idx;
    assign fill_data    = r_fill_data;
    assign fill_done    = r_fill_done;

endmodule

`default_nettype wire
